// File: rtl/frame_buffer_sched.sv
// -----------------------------------------------------------------------------
// frame_buffer_sched
//   Sequences a single-clock camera frame buffer built on a 6-bit simple
//   dual-port RAM holding IMG_W x IMG_H pixels. One camera frame is written
//   into the RAM, after which the LCD path reads it back with a wrap-around
//   pan offset (X_OFF, Y_OFF). After RECAP_FRAMES LCD frames, or on an
//   explicit capture_req, the scheduler waits for the next camera frame and
//   recaptures.
//
// Ports
//   PixelClk     in   system / pixel clock, rising edge
//   reset        in   asynchronous reset, active-high
//   cam_vsync    in   camera vsync, high = vertical blank, falling edge = frame start
//   cam_href     in   camera line valid, one pixel per clock while high
//   cam_data     in   8-bit camera luma
//   capture_req  in   one-cycle recapture request
//   lcd_vstart   in   one-cycle pulse at start of each LCD frame
//   lcd_de       in   LCD active-pixel enable
//   wr_en        out  RAM write strobe
//   wr_addr      out  RAM write address
//   wr_data      out  RAM write data (cam_data[7:2])
//   rd_addr      out  RAM read address
//   rd_valid     out  RAM dout holds a valid image pixel
//   frame_done   out  one-cycle pulse when a capture completes
//   short_frame  out  one-cycle pulse when a capture is aborted by vsync
//   state        out  0 = WAIT_VS, 1 = CAPTURE, 2 = SHOW
// -----------------------------------------------------------------------------
module frame_buffer_sched #(
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 180,
  parameter int ADDR_W       = 17,
  parameter int X_OFF        = 375,
  parameter int Y_OFF        = 28,
  parameter int RECAP_FRAMES = 16
) (
  input  logic              PixelClk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_req,
  input  logic              lcd_vstart,
  input  logic              lcd_de,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [5:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              frame_done,
  output logic              short_frame,
  output logic [1:0]        state
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] YBASE_START = ADDR_W'(Y_OFF * IMG_W);
  localparam logic [ADDR_W-1:0] LINE_STEP   = ADDR_W'(IMG_W);
  localparam logic [XW-1:0]     X_START     = XW'(X_OFF);
  localparam logic [XW-1:0]     X_LAST      = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_START     = YW'(Y_OFF);
  localparam logic [YW-1:0]     Y_LAST      = YW'(IMG_H - 1);
  localparam logic [7:0]        RECAP_LAST  = 8'(RECAP_FRAMES);

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_vs_q;
  logic                r_de_q;
  logic                r_de_d1;
  logic [ADDR_W-1:0]   r_wr_cnt;
  logic [7:0]          r_recap_cnt;
  logic [XW-1:0]       r_rd_x;
  logic [YW-1:0]       r_rd_y;
  logic [ADDR_W-1:0]   r_rd_ybase;

  logic                w_vs_fall;
  logic                w_vs_rise;
  logic                w_de_fall;
  logic                w_last_wr;
  logic                w_done;
  logic                w_short;
  logic [7:0]          w_recap_inc;
  logic                w_unused_lsbs;

  // The two luma LSBs are dropped by the 6-bit RAM.
  assign w_unused_lsbs = ^cam_data[1:0];

  assign w_vs_fall   = r_vs_q & ~cam_vsync;
  assign w_vs_rise   = ~r_vs_q & cam_vsync;
  assign w_de_fall   = r_de_q & ~lcd_de;
  assign w_last_wr   = cam_href & (r_wr_cnt == LAST_ADDR);
  assign w_recap_inc = r_recap_cnt + 8'd1;
  assign state       = r_state;

  // Next-state logic and one-cycle status pulse requests.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_short     = 1'b0;
    case (r_state)
      ST_WAIT_VS: begin
        if (w_vs_fall) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_state_nxt = ST_WAIT_VS;
        end
      end
      ST_CAPTURE: begin
        // Completion is checked first so a final write coinciding with
        // vsync rising still counts as a full frame.
        if (state_t'(r_state) == ST_CAPTURE && w_last_wr) begin
          w_state_nxt = ST_SHOW;
          w_done      = 1'b1;
        end else if (w_vs_rise) begin
          w_state_nxt = ST_WAIT_VS;
          w_short     = 1'b1;
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_SHOW: begin
        if (capture_req) begin
          w_state_nxt = ST_WAIT_VS;
        end else if (lcd_vstart && (w_recap_inc == RECAP_LAST)) begin
          w_state_nxt = ST_WAIT_VS;
        end else begin
          w_state_nxt = ST_SHOW;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_VS;
      end
    endcase
  end

  // State register, status pulses and recapture frame counter.
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_WAIT_VS;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      r_recap_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      frame_done  <= w_done;
      short_frame <= w_short;
      if (w_done) begin
        r_recap_cnt <= 8'd0;
      end else if ((r_state == ST_SHOW) && lcd_vstart && !capture_req) begin
        r_recap_cnt <= w_recap_inc;
      end
    end
  end

  // Input edge history and the two-stage read-valid pipeline.
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      r_vs_q   <= 1'b1;
      r_de_q   <= 1'b0;
      r_de_d1  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      r_vs_q   <= cam_vsync;
      r_de_q   <= lcd_de;
      // Stage 1 tracks the address register, stage 2 the RAM output register.
      r_de_d1  <= lcd_de & (r_state == ST_SHOW);
      rd_valid <= r_de_d1 & (r_state != ST_CAPTURE);
    end
  end

  // Camera write path: address counter plus registered RAM write port.
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 6'd0;
      r_wr_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      case (r_state)
        ST_WAIT_VS: begin
          if (w_vs_fall) begin
            r_wr_cnt <= '0;
          end
        end
        ST_CAPTURE: begin
          if (cam_href) begin
            wr_en   <= 1'b1;
            wr_addr <= r_wr_cnt;
            wr_data <= cam_data[7:2];
            // Hold at the last address so the counter cannot wrap.
            if (!w_last_wr) begin
              r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // LCD read path: panned x/y walk with an incrementally maintained line
  // base, so no multiply is needed to form rd_addr.
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      rd_addr    <= '0;
      r_rd_x     <= '0;
      r_rd_y     <= '0;
      r_rd_ybase <= '0;
    end else if (r_state == ST_SHOW) begin
      if (lcd_vstart) begin
        r_rd_x     <= X_START;
        r_rd_y     <= Y_START;
        r_rd_ybase <= YBASE_START;
      end else if (lcd_de) begin
        rd_addr <= r_rd_ybase + ADDR_W'(r_rd_x);
        if (r_rd_x == X_LAST) begin
          r_rd_x <= '0;
        end else begin
          r_rd_x <= r_rd_x + XW'(1);
        end
      end else if (w_de_fall) begin
        r_rd_x <= X_START;
        if (r_rd_y == Y_LAST) begin
          r_rd_y     <= '0;
          r_rd_ybase <= '0;
        end else begin
          r_rd_y     <= r_rd_y + YW'(1);
          r_rd_ybase <= r_rd_ybase + LINE_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_sched.sv
// Scoreboarded bench for frame_buffer_sched on a reduced image geometry.
module tb_frame_buffer_sched;

  localparam int W     = 40;
  localparam int H     = 12;
  localparam int AW    = 9;
  localparam int XO    = 25;
  localparam int YO    = 5;
  localparam int RF    = 2;
  localparam int TOTAL = W * H;

  logic          clk;
  logic          rst;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          capture_req;
  logic          lcd_vstart;
  logic          lcd_de;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [5:0]    wr_data;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          frame_done;
  logic          short_frame;
  logic [1:0]    state;

  frame_buffer_sched #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .X_OFF(XO), .Y_OFF(YO), .RECAP_FRAMES(RF)
  ) dut (
    .PixelClk(clk), .reset(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .capture_req(capture_req), .lcd_vstart(lcd_vstart),
    .lcd_de(lcd_de), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .frame_done(frame_done),
    .short_frame(short_frame), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected traffic queues: writes as {addr, data}, reads as addresses.
  logic [AW+5:0] wexp_q[$];
  logic [AW-1:0] rexp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int got_done = 0, got_short = 0, exp_done = 0, exp_short = 0;

  // Reference model: 0 waiting, 1 capturing, 2 showing.
  int m_state = 0;
  int m_cnt   = 0;
  int m_recap = 0;

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: consumes DUT output events and compares against queued expectations.
  initial begin : monitor
    logic [AW-1:0] prev_rd;
    logic [AW+5:0] e;
    logic [AW-1:0] ra;
    prev_rd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_en) begin
          if (wexp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = wexp_q.pop_front();
            check("wr_addr", wr_addr, e[AW+5:6]);
            check("wr_data", wr_data, e[5:0]);
          end
        end
        if (rd_valid) begin
          if (rexp_q.size() == 0) begin
            check("unexpected_rd_valid", 1, 0);
          end else begin
            ra = rexp_q.pop_front();
            check("rd_addr", prev_rd, ra);
          end
        end
        if (frame_done) begin
          got_done++;
          check("done_with_last_write", {wr_en, wr_addr}, {1'b1, AW'(TOTAL - 1)});
        end
        if (short_frame) got_short++;
      end
      prev_rd = rd_addr;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One camera pixel; the model follows the capture rules directly.
  task automatic cam_pixel();
    cam_href = 1'b1;
    cam_data = 8'($urandom);
    if (m_state == 1) begin
      wexp_q.push_back({AW'(m_cnt), cam_data[7:2]});
      if (m_cnt == TOTAL - 1) begin
        m_state = 2;
        m_recap = 0;
        exp_done++;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic vsync_rise();
    cam_vsync = 1'b1;
    if (m_state == 1) begin
      m_state = 0;
      exp_short++;
    end
  endtask

  // abort_line >= 0 raises vsync before that line; rise_on_last raises it on
  // the final pixel; extra_lines drives href lines beyond the frame.
  task automatic capture_frame(int abort_line, bit rise_on_last, int extra_lines);
    cam_vsync = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
      m_cnt   = 0;
    end
    tick(2);
    for (int l = 0; l < H + extra_lines; l++) begin
      if (abort_line >= 0 && l == abort_line) begin
        vsync_rise();
        tick(1);
        break;
      end
      for (int p = 0; p < W; p++) begin
        cam_pixel();
        if (rise_on_last && l == H - 1 && p == W - 1) vsync_rise();
        tick(1);
      end
      cam_href = 1'b0;
      if (m_state == 1) begin
        // Requests and LCD enables during capture must have no effect.
        capture_req = 1'b1;
        lcd_de      = 1'b1;
        tick(1);
        capture_req = 1'b0;
        lcd_de      = 1'b0;
      end
      tick(2);
    end
    vsync_rise();
    tick(3);
  endtask

  task automatic lcd_frame(int lines, int len, bit with_req);
    lcd_vstart  = 1'b1;
    capture_req = with_req;
    if (m_state == 2) begin
      if (with_req) begin
        m_state = 0;
      end else begin
        m_recap++;
        if (m_recap == RF) m_state = 0;
      end
    end
    tick(1);
    lcd_vstart  = 1'b0;
    capture_req = 1'b0;
    tick(2);
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < len; c++) begin
        lcd_de = 1'b1;
        if (m_state == 2) rexp_q.push_back(AW'(((YO + l) % H) * W + (XO + c) % W));
        tick(1);
      end
      lcd_de = 1'b0;
      tick(3);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_short_frame"}, short_frame, 0);
    check({tag, "_state"}, state, 0);
  endtask

  task automatic check_settled(string tag);
    tick(4);
    check({tag, "_state"}, state, m_state);
    check({tag, "_wq_empty"}, wexp_q.size(), 0);
    check({tag, "_rq_empty"}, rexp_q.size(), 0);
    check({tag, "_done_cnt"}, got_done, exp_done);
    check({tag, "_short_cnt"}, got_short, exp_short);
  endtask

  initial begin : stim
    rst = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'd0;
    capture_req = 1'b0; lcd_vstart = 1'b0; lcd_de = 1'b0;
    tick(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(3);

    // Full capture, with one extra href line that must be ignored.
    capture_frame(-1, 1'b0, 1);
    check_settled("full_capture");

    // Panned readout: lines longer than W wrap x, more than H lines wrap y.
    lcd_frame(H + 2, 60, 1'b0);
    check_settled("show_pan");

    // Second LCD frame reaches the recapture count.
    lcd_frame(1, 10, 1'b0);
    check_settled("recap_limit");

    // Aborted capture, then a full frame from address 0 where the final
    // write coincides with vsync rising.
    capture_frame(5, 1'b0, 0);
    check_settled("short_frame");
    capture_frame(-1, 1'b1, 0);
    check_settled("recapture_rise_on_last");

    // capture_req together with lcd_vstart.
    lcd_frame(2, 45, 1'b1);
    check_settled("req_with_vstart");

    // Plain capture_req while showing.
    capture_frame(-1, 1'b0, 0);
    lcd_frame(3, 40, 1'b0);
    capture_req = 1'b1;
    if (m_state == 2) m_state = 0;
    tick(1);
    capture_req = 1'b0;
    check_settled("req_alone");

    // Asynchronous reset in the middle of a capture.
    cam_vsync = 1'b0;
    m_state = 1;
    m_cnt = 0;
    tick(2);
    for (int p = 0; p < 200; p++) begin
      cam_pixel();
      tick(1);
    end
    cam_href = 1'b0;
    tick(2);
    check("pre_reset_wr_addr", wr_addr, 199);
    check("pre_reset_state", state, 1);
    #2;
    rst = 1'b1;
    cam_vsync = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    m_state = 0;
    tick(2);
    rst = 1'b0;
    tick(2);
    capture_frame(-1, 1'b0, 0);
    check_settled("after_reset_capture");

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
